instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory fetch handshake; owns the PC.
- Drives instrfetch/addr_imem toward IMEM and captures instr on instr_fetched.
- Hands each fetched word to decode through a valid/ready handshake.
- Handles branch/jump redirects, halt, and address faults. Sits between the PC/branch logic and IMEM in the multi-cycle RV32I core.

Parameters:
- RESET_PC, 32'h01000000, PC after reset; IMEM base address.
- IMEM_SIZE, 2048, IMEM size in bytes; the legal fetch window is [RESET_PC, RESET_PC+IMEM_SIZE-1].
- TIMEOUT, 15, maximum REQ cycles without instr_fetched before a fault is raised.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- instrfetch  out  1  fetch request to IMEM.
- addr_imem  out  32  fetch address; equals pc.
- instr  in  32  fetched word from IMEM; registered in IMEM.
- instr_fetched  in  1  IMEM completion flag; stays high while instrfetch stays high.
- fetch_valid  out  1  fetch_instr/fetch_pc hold a valid instruction.
- fetch_instr  out  32  captured instruction.
- fetch_pc  out  32  address of fetch_instr.
- fetch_ready  in  1  decode accepts the instruction.
- redirect_valid  in  1  branch/jump taken, one-cycle pulse.
- redirect_pc  in  32  redirect target.
- halt  in  1  stop fetching; level-sensitive.
- fetch_fault  out  1  sticky fault flag.
- fault_pc  out  32  offending address.

Behaviour:
- Reset (rst=1 at an edge):
  - pc=RESET_PC, state=IDLE.
  - instrfetch=0, fetch_valid=0, fetch_instr=0, fetch_pc=0.
  - fetch_fault=0, fault_pc=0, timeout counter=0.
  - Reset overrides everything, including mid-REQ.
- All outputs are registered. addr_imem = pc at all times.
- States: IDLE, REQ, DELIVER, FLUSH, HALTED, FAULT.
- IDLE: lasts one cycle after reset → REQ. If halt=1, go to HALTED instead.
- REQ:
  - instrfetch=1.
  - In the first REQ cycle, instr_fetched is stale and is ignored.
  - From the second REQ cycle on, instr_fetched=1 causes:
    - fetch_instr<=instr, fetch_pc<=pc, fetch_valid<=1, instrfetch<=0, state→DELIVER.
  - Nominal latency: instrfetch rises at cycle N; fetch_valid is high at cycle N+2.
  - The timeout counter increments on each REQ cycle. When it reaches TIMEOUT → FAULT with fault_pc=pc.
- DELIVER:
  - instrfetch=0. This guarantees IMEM clears instr_fetched before the next REQ.
  - fetch_valid held with fetch_instr and fetch_pc stable until fetch_ready=1.
  - On accept: fetch_valid<=0, pc<=pc+4 (mod 2^32). Then → HALTED if halt=1, else → REQ.
- Redirect (redirect_valid=1) has priority over accept and completion in the same cycle:
  - In REQ: pc<=redirect_pc, instrfetch<=0, discard any completion, → FLUSH.
  - In DELIVER: fetch_valid<=0, pc<=redirect_pc, → REQ.
  - In IDLE: pc<=redirect_pc, → REQ.
  - In HALTED/FAULT: ignored.
- FLUSH: instrfetch=0 for exactly one cycle, then → REQ.
- Address check is applied before entering REQ with a new pc. A fault is raised if any of:
  - pc[1:0]!=0;
  - pc<RESET_PC;
  - pc>RESET_PC+IMEM_SIZE-4.
  - On fault: state→FAULT, fetch_fault<=1, fault_pc<=pc, instrfetch stays 0.
  - Sequential wrap past the top of IMEM (pc+4 leaves the window) faults the same way.
- halt sampled in REQ: the in-flight fetch completes and delivers; HALTED is entered after accept.
- HALTED and FAULT are terminal until rst. Outputs in these states: instrfetch=0, fetch_valid=0.
- At most one outstanding request at any time. instrfetch is never high in two consecutive requests without a low cycle in between.

Test Plan:
- Basic fetch: reset, IMEM returns 32'h00000013 for 0x01000000, fetch_ready=1 → fetch_valid at cycle 3 after reset release. fetch_pc=0x01000000, fetch_instr=32'h00000013. Next addr_imem=0x01000004.
- Backpressure: fetch_ready=0 for 5 cycles → fetch_valid and fetch_instr stable, instrfetch=0 throughout. On accept, pc increments by exactly 4.
- Redirect mid-REQ: redirect_pc=0x01000100 while instrfetch=1 → one FLUSH cycle with instrfetch=0. The next request uses addr_imem=0x01000100; the old word is never delivered.
- Faults:
  - redirect_pc=0x01000102 → fetch_fault=1, fault_pc=0x01000102, no further instrfetch.
  - redirect_pc=0x01000800 → same behaviour.
- Timeout: instr_fetched held 0 → fetch_fault=1 after 15 REQ cycles, fault_pc=current pc.
- Halt/reset: halt=1 during REQ → word delivered, then HALTED with instrfetch=0. Then rst=1 for one edge → pc=0x01000000 and fetching restarts.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, runs the one-outstanding IMEM request
// handshake and hands each fetched word to decode over valid/ready.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0100_0000,
    parameter int unsigned IMEM_SIZE = 2048,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        rst,
    output logic        instrfetch,
    output logic [31:0] addr_imem,
    input  logic [31:0] instr,
    input  logic        instr_fetched,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
    input  logic        fetch_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);

    typedef enum logic [2:0] {IDLE, REQ, DELIVER, FLUSH, HALTED, FAULT} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_word_t;

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [31:0] PC_LAST = RESET_PC + 32'(IMEM_SIZE) - 32'd4;

    state_t        state, state_n;
    logic [31:0]   pc, pc_n;
    logic          instrfetch_n, fetch_valid_n, fetch_fault_n;
    logic [31:0]   fault_pc_n;
    fetch_word_t   word, word_n;
    logic [CW-1:0] tmo_cnt, tmo_cnt_n;
    logic          go_req;
    logic [31:0]   req_pc;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < RESET_PC) || (a > PC_LAST);
    endfunction

    assign addr_imem   = pc;
    assign fetch_instr = word.instr;
    assign fetch_pc    = word.pc;

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        instrfetch_n  = instrfetch;
        fetch_valid_n = fetch_valid;
        word_n        = word;
        fetch_fault_n = fetch_fault;
        fault_pc_n    = fault_pc;
        tmo_cnt_n     = tmo_cnt;
        go_req        = 1'b0;
        req_pc        = pc;
        case (state)
            IDLE: begin
                if (halt) begin
                    state_n = HALTED;
                end else begin
                    go_req = 1'b1;
                    req_pc = redirect_valid ? redirect_pc : pc;
                end
            end
            REQ: begin
                tmo_cnt_n = tmo_cnt + 1'b1;
                // tmo_cnt==0 marks the first REQ cycle, where instr_fetched is stale
                if (redirect_valid) begin
                    pc_n         = redirect_pc;
                    instrfetch_n = 1'b0;
                    state_n      = FLUSH;
                end else if (instr_fetched && tmo_cnt != '0) begin
                    word_n        = '{pc: pc, instr: instr};
                    fetch_valid_n = 1'b1;
                    instrfetch_n  = 1'b0;
                    state_n       = DELIVER;
                end else if (tmo_cnt == TMO_LAST) begin
                    instrfetch_n  = 1'b0;
                    fetch_fault_n = 1'b1;
                    fault_pc_n    = pc;
                    state_n       = FAULT;
                end
            end
            DELIVER: begin
                if (redirect_valid) begin
                    fetch_valid_n = 1'b0;
                    go_req        = 1'b1;
                    req_pc        = redirect_pc;
                end else if (fetch_ready) begin
                    fetch_valid_n = 1'b0;
                    if (halt) begin
                        state_n = HALTED;
                        pc_n    = pc + 32'd4;
                    end else begin
                        go_req = 1'b1;
                        req_pc = pc + 32'd4;
                    end
                end
            end
            FLUSH: begin
                go_req = 1'b1;
                req_pc = pc;
            end
            default: ;
        endcase

        // every entry into REQ with a new pc passes through the window check
        if (go_req) begin
            pc_n = req_pc;
            if (addr_bad(req_pc)) begin
                instrfetch_n  = 1'b0;
                fetch_fault_n = 1'b1;
                fault_pc_n    = req_pc;
                state_n       = FAULT;
            end else begin
                instrfetch_n = 1'b1;
                tmo_cnt_n    = '0;
                state_n      = REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instrfetch  <= 1'b0;
            fetch_valid <= 1'b0;
            word        <= '0;
            fetch_fault <= 1'b0;
            fault_pc    <= '0;
            tmo_cnt     <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instrfetch  <= instrfetch_n;
            fetch_valid <= fetch_valid_n;
            word        <= word_n;
            fetch_fault <= fetch_fault_n;
            fault_pc    <= fault_pc_n;
            tmo_cnt     <= tmo_cnt_n;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed handshake/fault/halt cases, then a
// randomized run scored against an expected-PC stream model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0100_0000;
    localparam int          IMEM_SIZE = 2048;
    localparam int          TIMEOUT   = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instrfetch;
    logic [31:0] addr_imem;
    logic [31:0] instr = '0;
    logic        instr_fetched = 1'b0;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        fetch_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .IMEM_SIZE(IMEM_SIZE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .instrfetch(instrfetch), .addr_imem(addr_imem),
        .instr(instr), .instr_fetched(instr_fetched), .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .fetch_fault(fetch_fault), .fault_pc(fault_pc)
    );

    // IMEM: registered response after a random per-request latency; held while requested
    logic imem_en = 1'b1;
    int   imem_lat_max = 0;
    int   lat_cnt = 0;
    int   lat_tgt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RESET_PC) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    always @(posedge clk) begin
        if (!instrfetch || !imem_en) begin
            instr_fetched <= 1'b0;
            lat_cnt       <= 0;
            lat_tgt       <= int'($urandom_range(imem_lat_max, 0));
            instr         <= $urandom;
        end else if (!instr_fetched) begin
            if (lat_cnt >= lat_tgt) begin
                instr_fetched <= 1'b1;
                instr         <= mem_word(addr_imem);
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h exp %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return instrfetch;
            1:       return fetch_valid;
            default: return fetch_fault;
        endcase
    endfunction

    task automatic wait_hi(input string tag, input int sel, input int max);
        int n = 0;
        while (sig(sel) !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk(tag, 32'(sig(sel)), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        halt = 1'b0;
        @(negedge clk);
        tick();
        rst = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic fault_case(input string tag, input logic [31:0] target, input bit in_dlv);
        fetch_ready = 1'b0;
        do_reset();
        wait_hi({tag, "_arm"}, in_dlv ? 1 : 0, 10);
        redirect(target);
        wait_hi({tag, "_flag"}, 2, 5);
        chk({tag, "_pc"}, fault_pc, target);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_no_req"}, 32'(instrfetch), 32'd0);
            chk({tag, "_no_vld"}, 32'(fetch_valid), 32'd0);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int          cyc, first_if, cnt, ndlv;
        logic [31:0] pc0, i0, exp_pc;

        // basic fetch and reset state
        imem_en = 1'b1;
        imem_lat_max = 0;
        fetch_ready = 1'b1;
        do_reset();
        chk("rst_instrfetch", 32'(instrfetch), 32'd0);
        chk("rst_valid", 32'(fetch_valid), 32'd0);
        chk("rst_instr", fetch_instr, 32'd0);
        chk("rst_fpc", fetch_pc, 32'd0);
        chk("rst_fault", 32'(fetch_fault), 32'd0);
        chk("rst_fault_pc", fault_pc, 32'd0);
        chk("rst_addr", addr_imem, RESET_PC);
        cyc = 0;
        first_if = -1;
        while (!fetch_valid && cyc < 20) begin
            tick();
            cyc++;
            if (instrfetch && first_if < 0) first_if = cyc;
        end
        chk("basic_req_cycle", 32'(first_if), 32'd1);
        chk("basic_latency", 32'(cyc), 32'd3);
        chk("basic_fpc", fetch_pc, RESET_PC);
        chk("basic_instr", fetch_instr, 32'h0000_0013);
        tick();
        chk("basic_next_addr", addr_imem, RESET_PC + 32'd4);
        chk("basic_accepted", 32'(fetch_valid), 32'd0);

        // backpressure
        fetch_ready = 1'b0;
        imem_lat_max = 2;
        wait_hi("bp_valid", 1, 20);
        pc0 = fetch_pc;
        i0  = fetch_instr;
        chk("bp_fpc", pc0, RESET_PC + 32'd4);
        chk("bp_instr", i0, mem_word(RESET_PC + 32'd4));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_vld", 32'(fetch_valid), 32'd1);
            chk("bp_hold_instr", fetch_instr, i0);
            chk("bp_hold_pc", fetch_pc, pc0);
            chk("bp_no_req", 32'(instrfetch), 32'd0);
        end
        fetch_ready = 1'b1;
        tick();
        chk("bp_pc_inc", addr_imem, pc0 + 32'd4);
        chk("bp_vld_drop", 32'(fetch_valid), 32'd0);

        // redirect in the second REQ cycle, while a completion is pending
        imem_lat_max = 0;
        do_reset();
        tick();
        tick();
        chk("rd_in_req", 32'(instrfetch), 32'd1);
        redirect(32'h0100_0100);
        chk("rd_flush_req", 32'(instrfetch), 32'd0);
        chk("rd_flush_vld", 32'(fetch_valid), 32'd0);
        chk("rd_flush_addr", addr_imem, 32'h0100_0100);
        tick();
        chk("rd_req_again", 32'(instrfetch), 32'd1);
        chk("rd_req_addr", addr_imem, 32'h0100_0100);
        wait_hi("rd_valid", 1, 10);
        chk("rd_fpc", fetch_pc, 32'h0100_0100);
        chk("rd_instr", fetch_instr, mem_word(32'h0100_0100));

        // address faults
        fault_case("flt_misalign", 32'h0100_0102, 1'b0);
        fault_case("flt_above", 32'h0100_0800, 1'b1);
        fault_case("flt_below", 32'h00FF_FFFC, 1'b0);

        // last legal word, then sequential step off the top
        fetch_ready = 1'b1;
        do_reset();
        wait_hi("wrap_arm", 0, 10);
        redirect(32'h0100_07FC);
        wait_hi("wrap_valid", 1, 10);
        chk("wrap_fpc", fetch_pc, 32'h0100_07FC);
        wait_hi("wrap_flag", 2, 4);
        chk("wrap_fault_pc", fault_pc, 32'h0100_0800);
        chk("wrap_no_req", 32'(instrfetch), 32'd0);

        // timeout
        imem_en = 1'b0;
        do_reset();
        cnt = 0;
        for (int i = 0; i < 40 && !fetch_fault; i++) begin
            tick();
            if (instrfetch) cnt++;
        end
        chk("tmo_req_cycles", 32'(cnt), 32'(TIMEOUT));
        chk("tmo_flag", 32'(fetch_fault), 32'd1);
        chk("tmo_fault_pc", fault_pc, RESET_PC);
        chk("tmo_no_req", 32'(instrfetch), 32'd0);
        imem_en = 1'b1;

        // halt during REQ, then reset restarts fetching
        imem_lat_max = 1;
        fetch_ready = 1'b1;
        do_reset();
        wait_hi("halt_arm", 0, 10);
        halt = 1'b1;
        wait_hi("halt_valid", 1, 10);
        chk("halt_fpc", fetch_pc, RESET_PC);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("halt_no_req", 32'(instrfetch), 32'd0);
            chk("halt_no_vld", 32'(fetch_valid), 32'd0);
        end
        do_reset();
        chk("halt_rst_addr", addr_imem, RESET_PC);
        wait_hi("halt_restart", 1, 10);
        chk("halt_restart_fpc", fetch_pc, RESET_PC);

        // randomized run against the expected pc stream
        imem_lat_max = 4;
        do_reset();
        exp_pc = RESET_PC;
        ndlv = 0;
        for (int i = 0; i < 600; i++) begin
            chk("rnd_addr", addr_imem, exp_pc);
            chk("rnd_no_fault", 32'(fetch_fault), 32'd0);
            if (fetch_valid) chk("rnd_one_outstanding", 32'(instrfetch), 32'd0);
            fetch_ready    = ($urandom_range(3, 0) != 0);
            redirect_valid = 1'b0;
            if ((instrfetch || fetch_valid) && $urandom_range(15, 0) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = RESET_PC + 32'(4 * $urandom_range(255, 0));
            end
            if (redirect_valid) begin
                exp_pc = redirect_pc;
            end else if (fetch_valid && fetch_ready) begin
                chk("rnd_fpc", fetch_pc, exp_pc);
                chk("rnd_instr", fetch_instr, mem_word(exp_pc));
                exp_pc += 32'd4;
                ndlv++;
            end
            tick();
        end
        redirect_valid = 1'b0;
        chk("rnd_progress", 32'(ndlv > 20), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
